mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port memory responder that services the pipelined datapath's instruction-fetch port (port 1, read-only) and data port (port 2, read/write) from a single word-wide physical memory. It sits between the CPU datapath and physical memory or cache. It arbitrates between the two ports, registers the winning request onto the physical interface, and returns per-port response pulses with registered read data.

## Interface
- No parameters; word width is lc3b_word (16 bits).
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- mem_read1  in  1  port 1 read request (level, held until mem_resp1)
- mem_addr1  in  16  port 1 address
- mem_resp1  out  1  port 1 completion pulse
- mem_rdata1  out  16  port 1 read data, valid when mem_resp1=1
- mem_read2  in  1  port 2 read request
- mem_write2  in  1  port 2 write request
- mem_addr2  in  16  port 2 address
- mem_wdata2  in  16  port 2 write data
- mem_resp2  out  1  port 2 completion pulse
- mem_rdata2  out  16  port 2 read data, valid when mem_resp2=1 for a read
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_address  out  16  physical address
- pmem_wdata  out  16  physical write data
- pmem_rdata  in  16  physical read data, valid with pmem_resp
- pmem_resp  in  1  physical completion, one cycle

## Operation
- States: IDLE, BUSY, DONE. Register last_grant (0=port 1, 1=port 2).
- IDLE: sample requests. Port 2 pending = mem_read2|mem_write2.
  - Only one port pending: grant it.
  - Both pending: grant the port not equal to last_grant (round-robin).
  - On grant: capture address, write data and op into registers; set last_grant; go to BUSY.
- Port 2 with read and write both high: treated as a write.
- BUSY: pmem_read or pmem_write held high with captured address/wdata.
  - Input request changes are ignored.
  - On pmem_resp=1: capture pmem_rdata into the granted port's rdata register (reads only); go to DONE.
- DONE: drop pmem strobes; assert the granted port's mem_respX for exactly one cycle; no sampling; go to IDLE.
- mem_rdata1 and mem_rdata2 hold their last captured value until the next read completion on that port. A write does not alter mem_rdata2.
- Requester contract: deassert the request on the edge that ends the mem_respX cycle. A request still high in the following IDLE is a new request.
- Reset (reset_n=0 at an edge, any state): state goes to IDLE; last_grant goes to 1, so port 1 wins the first tie. Any in-flight physical transaction is abandoned, and a late pmem_resp arriving in IDLE is ignored.

## Timing
- Reset values: mem_resp1=0, mem_resp2=0, mem_rdata1=0, mem_rdata2=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
- All outputs are registered; none is combinational from inputs.
- Request high in IDLE at cycle 0 → pmem strobe high from cycle 1.
- pmem_resp at cycle k (k≥1) → mem_respX high in cycle k+1 → IDLE in cycle k+2.
- Minimum latency from request to response: 2 cycles (zero-wait memory). Back-to-back service period: k+2 cycles.
- A pmem_resp received in the same cycle the strobe first rises (cycle 1) is legal.
- Strobes and address stay stable for the whole of BUSY. pmem_write and pmem_read are never high together.

## Test plan
- Reset then port 1 read of 0x3000; memory returns 0x1234 after 3 wait cycles. Expected: pmem_read high in cycles 1–4, mem_resp1 pulse in cycle 5 with mem_rdata1=0x1234, mem_resp2=0 throughout.
- Port 2 write of 0xBEEF to 0x4002. Expected: pmem_write=1, pmem_address=0x4002, pmem_wdata=0xBEEF; mem_resp2 pulses once; mem_rdata2 is unchanged.
- Both ports request in the same cycle after reset. Expected: port 1 is served first. With both held, the next grant goes to port 2, then port 1: strict alternation.
- Input address changes to 0x5555 during BUSY. Expected: pmem_address keeps the captured value.
- reset_n low during BUSY, then a late pmem_resp in IDLE. Expected: all outputs return to 0, and no mem_respX pulse appears.
- Port 2 with read and write both high. Expected: only pmem_write is asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin responder that serves an instruction-fetch port and
//               a data port from one word-wide physical memory interface.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read1,
    input  logic [15:0] mem_addr1,
    output logic        mem_resp1,
    output logic [15:0] mem_rdata1,
    input  logic        mem_read2,
    input  logic        mem_write2,
    input  logic [15:0] mem_addr2,
    input  logic [15:0] mem_wdata2,
    output logic        mem_resp2,
    output logic [15:0] mem_rdata2,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic        r_sel_p2;
    logic        r_pmem_read;
    logic        r_pmem_write;
    logic [15:0] r_pmem_address;
    logic [15:0] r_pmem_wdata;
    logic        r_resp1;
    logic        r_resp2;
    logic [15:0] r_rdata1;
    logic [15:0] r_rdata2;
    logic        w_req1;
    logic        w_req2;
    logic        w_grant;
    logic        w_grant_p2;
    logic        w_complete;

    assign w_req1     = mem_read1;
    assign w_req2     = mem_read2 | mem_write2;
    assign w_complete = (r_state == S_BUSY) && pmem_resp;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_p2   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req1 || w_req2) begin
                    w_grant      = 1'b1;
                    // On a tie, the port that did not win last time goes next
                    w_grant_p2   = w_req2 && (!w_req1 || !r_last_grant);
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY:  if (pmem_resp) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant   <= 1'b1;
            r_sel_p2       <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 16'h0000;
            r_pmem_wdata   <= 16'h0000;
            r_resp1        <= 1'b0;
            r_resp2        <= 1'b0;
            r_rdata1       <= 16'h0000;
            r_rdata2       <= 16'h0000;
        end else begin
            r_resp1 <= 1'b0;
            r_resp2 <= 1'b0;
            if (w_grant) begin
                r_last_grant <= w_grant_p2;
                r_sel_p2     <= w_grant_p2;
                if (w_grant_p2) begin
                    // Read and write together resolves to a write
                    r_pmem_address <= mem_addr2;
                    r_pmem_wdata   <= mem_wdata2;
                    r_pmem_write   <= mem_write2;
                    r_pmem_read    <= ~mem_write2;
                end else begin
                    r_pmem_address <= mem_addr1;
                    r_pmem_write   <= 1'b0;
                    r_pmem_read    <= 1'b1;
                end
            end
            if (w_complete) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                if (r_sel_p2) begin
                    r_resp2 <= 1'b1;
                    if (!r_pmem_write) r_rdata2 <= pmem_rdata;
                end else begin
                    r_resp1  <= 1'b1;
                    r_rdata1 <= pmem_rdata;
                end
            end
        end
    end

    assign mem_resp1    = r_resp1;
    assign mem_resp2    = r_resp2;
    assign mem_rdata1   = r_rdata1;
    assign mem_rdata2   = r_rdata2;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized bench for mem_port_arbiter against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read1;
    logic [15:0] mem_addr1;
    logic        mem_resp1;
    logic [15:0] mem_rdata1;
    logic        mem_read2;
    logic        mem_write2;
    logic [15:0] mem_addr2;
    logic [15:0] mem_wdata2;
    logic        mem_resp2;
    logic [15:0] mem_rdata2;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read1    (mem_read1),
        .mem_addr1    (mem_addr1),
        .mem_resp1    (mem_resp1),
        .mem_rdata1   (mem_rdata1),
        .mem_read2    (mem_read2),
        .mem_write2   (mem_write2),
        .mem_addr2    (mem_addr2),
        .mem_wdata2   (mem_wdata2),
        .mem_resp2    (mem_resp2),
        .mem_rdata2   (mem_rdata2),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int r_checks = 0;
    int r_passed = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        r_checks++;
        if (got === exp) r_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Backing store of the physical memory
    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hA5A5;
    endfunction

    // Transaction-level expectation
    bit          m_active, m_respc, m_last_p2, m_wr, just_reset, late_resp;
    int          m_port, wait_left;
    logic [15:0] m_addr, m_wdata, m_rd1, m_rd2;

    // Requesters
    bit          p1_pend, p2_pend, p2_rd, p2_wr;
    logic [15:0] p1_addr, p2_addr, p2_wdata;

    initial begin
        reset_n    = 1'b0;
        mem_read1  = 1'b0;
        mem_addr1  = 16'h0;
        mem_read2  = 1'b0;
        mem_write2 = 1'b0;
        mem_addr2  = 16'h0;
        mem_wdata2 = 16'h0;
        pmem_rdata = 16'h0;
        pmem_resp  = 1'b0;
        m_active = 0; m_respc = 0; m_last_p2 = 1; m_wr = 0; late_resp = 0;
        m_port = 1; wait_left = 0; m_addr = 0; m_wdata = 0; m_rd1 = 0; m_rd2 = 0;
        just_reset = 1;
        // Tie immediately after reset: port 1 must win first
        p1_pend = 1; p1_addr = 16'h3000;
        p2_pend = 1; p2_rd = 0; p2_wr = 1; p2_addr = 16'h4002; p2_wdata = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit do_rst;
            int op;

            if (just_reset) begin
                check_val("rst_addr", pmem_address, 16'h0000);
                check_val("rst_wdata", pmem_wdata, 16'h0000);
                just_reset = 0;
            end
            check_val("pmem_read", {15'd0, pmem_read}, {15'd0, m_active && !m_wr});
            check_val("pmem_write", {15'd0, pmem_write}, {15'd0, m_active && m_wr});
            if (m_active) begin
                check_val("pmem_address", pmem_address, m_addr);
                if (m_wr) check_val("pmem_wdata", pmem_wdata, m_wdata);
            end
            check_val("mem_resp1", {15'd0, mem_resp1}, {15'd0, m_respc && m_port == 1});
            check_val("mem_resp2", {15'd0, mem_resp2}, {15'd0, m_respc && m_port == 2});
            check_val("mem_rdata1", mem_rdata1, m_rd1);
            check_val("mem_rdata2", mem_rdata2, m_rd2);

            do_rst = m_active && ($urandom_range(0, 39) == 0);

            // Requesters drop a request once its response is seen, may reissue at once
            if (m_respc) begin
                if (m_port == 1) p1_pend = 0;
                else             p2_pend = 0;
            end
            if (!p1_pend && $urandom_range(0, 2) == 0) begin
                p1_pend = 1;
                p1_addr = 16'($urandom);
            end
            if (!p2_pend && $urandom_range(0, 2) == 0) begin
                p2_pend  = 1;
                op       = $urandom_range(0, 2);
                p2_rd    = (op != 1);
                p2_wr    = (op != 0);
                p2_addr  = ($urandom_range(0, 1) == 0) ? p1_addr : 16'($urandom);
                p2_wdata = 16'($urandom);
            end
            mem_read1  = p1_pend;
            mem_addr1  = (p1_pend && !(m_active && m_port == 1)) ? p1_addr
                         : ($urandom_range(0, 1) == 0 ? 16'h5555 : 16'($urandom));
            mem_read2  = p2_pend && p2_rd;
            mem_write2 = p2_pend && p2_wr;
            mem_addr2  = (p2_pend && !(m_active && m_port == 2)) ? p2_addr
                         : ($urandom_range(0, 1) == 0 ? 16'h5555 : 16'($urandom));
            mem_wdata2 = (p2_pend && !(m_active && m_port == 2)) ? p2_wdata : 16'($urandom);

            pmem_resp  = 1'b0;
            pmem_rdata = 16'($urandom);
            if (late_resp) begin
                pmem_resp = 1'b1;
                late_resp = 0;
            end else if (m_active) begin
                if (wait_left == 0) begin
                    pmem_resp = 1'b1;
                    if (!m_wr) pmem_rdata = mem_rd(m_addr);
                end else begin
                    wait_left--;
                end
            end
            reset_n = !do_rst;

            // Predict what the next cycle must show
            if (do_rst) begin
                m_active = 0; m_respc = 0; m_last_p2 = 1;
                m_rd1 = 0; m_rd2 = 0;
                p1_pend = 0; p2_pend = 0;
                late_resp = 1; just_reset = 1;
            end else if (m_respc) begin
                m_respc = 0;
            end else if (m_active) begin
                if (pmem_resp) begin
                    if (m_wr)             mem[m_addr] = m_wdata;
                    else if (m_port == 1) m_rd1 = pmem_rdata;
                    else                  m_rd2 = pmem_rdata;
                    m_active = 0;
                    m_respc  = 1;
                end
            end else if (p1_pend || p2_pend) begin
                if (p1_pend && p2_pend) m_port = m_last_p2 ? 1 : 2;
                else                    m_port = p1_pend ? 1 : 2;
                m_last_p2 = (m_port == 2);
                if (m_port == 1) begin
                    m_addr = p1_addr; m_wr = 0;
                end else begin
                    m_addr = p2_addr; m_wr = p2_wr; m_wdata = p2_wdata;
                end
                wait_left = $urandom_range(0, 3);
                m_active  = 1;
            end

            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
